// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_stretch block: mode encodings and FSM states.
package decoder_pkg;

    localparam logic [1:0] MODE_PULSE   = 2'b00;
    localparam logic [1:0] MODE_STRETCH = 2'b01;
    localparam logic [1:0] MODE_STICKY  = 2'b10;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with range detection for non power-of-two widths.
module onehot_dec #(
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = $clog2(DOUT_WIDTH)
) (
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [DOUT_WIDTH-1:0] onehot,
    output logic                  in_range
);

    always_comb begin
        onehot   = '0;
        in_range = 32'(sel) < DOUT_WIDTH;
        for (int unsigned i = 0; i < DOUT_WIDTH; i++) begin
            if (32'(sel) == i) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_stretch.sv
// Registered one-hot decoder with valid/ready input and PULSE, STRETCH and STICKY output modes.
module decoder_stretch
    import decoder_pkg::*;
#(
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = $clog2(DOUT_WIDTH),
    parameter int unsigned STRETCH_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [STRETCH_W-1:0]  stretch_len,
    input  logic                  clear,
    input  logic [SEL_WIDTH-1:0]  din,
    input  logic                  din_v,
    output logic                  din_rdy,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_v,
    output logic                  err,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [STRETCH_W-1:0]  cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  err_q, err_d;
    logic [DOUT_WIDTH-1:0] dec;
    logic                  in_range;
    logic                  accept;

    onehot_dec #(
        .DOUT_WIDTH (DOUT_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_dec (
        .sel      (din),
        .onehot   (dec),
        .in_range (in_range)
    );

    assign din_rdy = (state_q == IDLE) || (mode_q != MODE_STRETCH);
    assign accept  = din_v && din_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        err_d   = err_q;

        // Evolve the output as if nothing were accepted; an accept then overlays it.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            dout_d  = '0;
            err_d   = 1'b0;
        end else if (state_q == HOLD) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                dout_d  = '0;
            end else begin
                cnt_d = cnt_q - STRETCH_W'(1);
            end
        end else if (mode_q != MODE_STICKY) begin
            dout_d = '0;
        end

        if (accept) begin
            if (!in_range) begin
                err_d = 1'b1;
            end else begin
                mode_d = mode;
                case (mode)
                    MODE_STRETCH: begin
                        dout_d  = dec;
                        state_d = HOLD;
                        cnt_d   = stretch_len;
                    end
                    MODE_STICKY: dout_d = dout_d | dec;
                    default:     dout_d = dec;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_PULSE;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign dout   = dout_q;
    assign dout_v = |dout_q;
    assign err    = err_q;
    assign busy   = (state_q == HOLD);

endmodule

// File: tb/tb_decoder_stretch.sv
// Directed bench for decoder_stretch: an 8-output instance for the modes, a 6-output one for range errors.
module tb_decoder_stretch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] stretch_len = 4'd0;
    logic       clear = 1'b0;
    logic [2:0] din = 3'd0;
    logic       din_v = 1'b0;

    logic       rdy8, dv8, err8, busy8;
    logic [7:0] dout8;
    logic       rdy6, dv6, err6, busy6;
    logic [5:0] dout6;

    int total = 0;
    int bad   = 0;

    decoder_stretch #(.DOUT_WIDTH(8), .STRETCH_W(4)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .stretch_len (stretch_len),
        .clear       (clear),
        .din         (din),
        .din_v       (din_v),
        .din_rdy     (rdy8),
        .dout        (dout8),
        .dout_v      (dv8),
        .err         (err8),
        .busy        (busy8)
    );

    decoder_stretch #(.DOUT_WIDTH(6), .STRETCH_W(4)) dut6 (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .stretch_len (stretch_len),
        .clear       (clear),
        .din         (din),
        .din_v       (din_v),
        .din_rdy     (rdy6),
        .dout        (dout6),
        .dout_v      (dv6),
        .err         (err6),
        .busy        (busy6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] len;
        logic       clr;
        logic [2:0] din;
        logic       v;
        logic [7:0] dout;
        logic       dv;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] m, input logic [3:0] l, input logic c,
                       input logic [2:0] d, input logic v, input logic [7:0] o,
                       input logic ov, input logic b, input logic r);
        vec_t x;
        x.mode = m; x.len = l; x.clr = c; x.din = d; x.v = v;
        x.dout = o; x.dv = ov; x.busy = b; x.rdy = r;
        vecs.push_back(x);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] o, input logic ov,
                          input logic b, input logic r);
        chk8({tag, ".dout"}, dout8, o);
        chk1({tag, ".dout_v"}, dv8, ov);
        chk1({tag, ".busy"}, busy8, b);
        chk1({tag, ".din_rdy"}, rdy8, r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        din_v = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        // mode len clr din v | dout dv busy rdy (values after the edge)
        add(2'b00, 4'd0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        add(2'b00, 4'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b00, 4'd0, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
        add(2'b00, 4'd0, 1'b0, 3'd6, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        add(2'b00, 4'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b01, 4'd3, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd7, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd7, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd7, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b01, 4'd3, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd3, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b01, 4'd0, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
        add(2'b01, 4'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b0, 3'd4, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b0, 3'd1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b0, 3'd0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        add(2'b10, 4'd0, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        add(2'b11, 4'd0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        add(2'b11, 4'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset values while rst_n is held low
        step();
        check8("reset", 8'h00, 1'b0, 1'b0, 1'b1);
        chk1("reset.err", err8, 1'b0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            mode        = vecs[i].mode;
            stretch_len = vecs[i].len;
            clear       = vecs[i].clr;
            din         = vecs[i].din;
            din_v       = vecs[i].v;
            step();
            check8($sformatf("vec%0d", i), vecs[i].dout, vecs[i].dv, vecs[i].busy, vecs[i].rdy);
            chk1($sformatf("vec%0d.err", i), err8, 1'b0);
        end
        idle_in();

        // Out-of-range on the 6-output instance
        mode = 2'b10; clear = 1'b1; step(); clear = 1'b0;
        chk1("oor.clr0.err", err6, 1'b0);
        din = 3'd2; din_v = 1'b1; step();
        chk8("oor.d2", {2'b00, dout6}, 8'h04);
        din = 3'd6; step();
        chk1("oor.d6.err", err6, 1'b1);
        chk8("oor.d6.dout", {2'b00, dout6}, 8'h04);
        din = 3'd7; step();
        chk1("oor.d7.err", err6, 1'b1);
        chk8("oor.d7.dout", {2'b00, dout6}, 8'h04);
        chk1("oor.d7.dv", dv6, 1'b1);
        din_v = 1'b0; clear = 1'b1; step();
        chk1("oor.clr.err", err6, 1'b0);
        chk8("oor.clr.dout", {2'b00, dout6}, 8'h00);
        din = 3'd7; din_v = 1'b1; step();
        chk1("oor.clr_acc.err", err6, 1'b1);
        chk8("oor.clr_acc.dout", {2'b00, dout6}, 8'h00);
        idle_in(); clear = 1'b1; step(); clear = 1'b0;
        chk1("oor.final.err", err6, 1'b0);

        // Clear aborts a long hold at hold cycle 5
        mode = 2'b01; stretch_len = 4'd15; din = 3'd0; din_v = 1'b1; step();
        din_v = 1'b0;
        check8("abort.start", 8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check8("abort.c5", 8'h01, 1'b1, 1'b1, 1'b0);
        clear = 1'b1; step(); clear = 1'b0;
        check8("abort.clr", 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset dropped at hold cycle 5: immediate, no pulse after release
        din_v = 1'b1; step();
        din_v = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check8("rst.c5", 8'h01, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0; #1;
        check8("rst.async", 8'h00, 1'b0, 1'b0, 1'b1);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check8($sformatf("rst.after%0d", i), 8'h00, 1'b0, 1'b0, 1'b1);
        end

        // Mode change mid-hold is ignored until the hold ends
        mode = 2'b01; stretch_len = 4'd5; din = 3'd3; din_v = 1'b1; step();
        din_v = 1'b0; mode = 2'b10;
        check8("mchg.c0", 8'h08, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step();
            check8($sformatf("mchg.c%0d", i), 8'h08, 1'b1, 1'b1, 1'b0);
        end
        step();
        check8("mchg.end", 8'h00, 1'b0, 1'b0, 1'b1);
        din = 3'd5; din_v = 1'b1; step();
        check8("mchg.st1", 8'h20, 1'b1, 1'b0, 1'b1);
        din = 3'd1; step();
        check8("mchg.st2", 8'h22, 1'b1, 1'b0, 1'b1);
        idle_in(); step();
        check8("mchg.st3", 8'h22, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
